// File: rtl/pixel_mem_arbiter_if.sv
// Bus bundle between the pixel memory arbiter and its surroundings:
// display read port, host write/clear requests, and the single-port memory.
//
// Handshake semantics:
//   - disp_rd is a one-cycle strobe; its pixel returns exactly one cycle later
//     with disp_valid=1.
//   - wr_req is a level request: wr_addr/wr_sel/wr_pix stay stable until the
//     cycle in which wr_ack pulses; the request may drop on the following edge.
//   - clr_req is sampled only when the arbiter is idle and free to grant;
//     clr_done pulses for one cycle after the last word has been written.
interface pixel_mem_arbiter_if;
  logic        disp_rd;
  logic [8:0]  disp_addr;
  logic [2:0]  disp_sel;
  logic        mem_row;
  logic [3:0]  disp_pixel;
  logic        disp_valid;
  logic        wr_req;
  logic [8:0]  wr_addr;
  logic [2:0]  wr_sel;
  logic [3:0]  wr_pix;
  logic        wr_ack;
  logic        clr_req;
  logic [3:0]  clr_color;
  logic        clr_done;
  logic        busy;
  logic        conflict;
  logic [8:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  disp_rd, disp_addr, disp_sel, mem_row,
    input  wr_req, wr_addr, wr_sel, wr_pix,
    input  clr_req, clr_color, mem_rdata,
    output disp_pixel, disp_valid, wr_ack, clr_done, busy, conflict,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output disp_rd, disp_addr, disp_sel, mem_row,
    output wr_req, wr_addr, wr_sel, wr_pix,
    output clr_req, clr_color, mem_rdata,
    input  disp_pixel, disp_valid, wr_ack, clr_done, busy, conflict,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/pixel_mem_arbiter.sv
// Single-port frame-buffer arbiter. Display reads always win the memory;
// host pixel writes are done as read-modify-write, and a clear fills every
// word with one colour, stalling whenever the display needs the memory.
module pixel_mem_arbiter #(
  parameter int WORDS = 384
) (
  input  logic                  clk_25,
  input  logic                  rst,
  pixel_mem_arbiter_if.slave    bus,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_RD = 2'd1,
    WR_WB = 2'd2,
    CLR   = 2'd3
  } state_t;

  localparam logic [8:0] LAST_PTR = 9'(WORDS - 1);

  state_t      state_q, state_d;
  logic [8:0]  ptr_q, ptr_d;
  logic [3:0]  color_q, color_d;
  logic        conflict_q, conflict_d;
  logic        clr_done_q, clr_done_d;
  logic        disp_valid_q;
  logic [2:0]  disp_sel_q;

  logic [8:0]  addr_d;
  logic        we_d;
  logic [31:0] wdata_d;
  logic        ack_d;

  // Next state and the one memory operation of this cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    color_d    = color_q;
    conflict_d = conflict_q;
    clr_done_d = 1'b0;
    addr_d     = 9'd0;
    we_d       = 1'b0;
    wdata_d    = 32'd0;
    ack_d      = 1'b0;

    // The display read owns the memory whenever it is present.
    if (bus.disp_rd) begin
      addr_d = bus.disp_addr;
    end

    case (state_q)
      IDLE: begin
        if (!bus.disp_rd && !bus.mem_row) begin
          if (bus.clr_req) begin
            color_d = bus.clr_color;
            ptr_d   = 9'd0;
            state_d = CLR;
          end else if (bus.wr_req) begin
            state_d = WR_RD;
          end
        end
      end
      WR_RD: begin
        if (bus.disp_rd) begin
          // Abandon the RMW; wr_req is still held so it is regranted later.
          conflict_d = 1'b1;
          state_d    = IDLE;
        end else begin
          addr_d  = bus.wr_addr;
          state_d = WR_WB;
        end
      end
      WR_WB: begin
        if (bus.disp_rd) begin
          conflict_d = 1'b1;
          state_d    = IDLE;
        end else begin
          addr_d  = bus.wr_addr;
          we_d    = 1'b1;
          wdata_d = bus.mem_rdata;
          wdata_d[{bus.wr_sel, 2'b00} +: 4] = bus.wr_pix;
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      CLR: begin
        if (!bus.disp_rd && !bus.mem_row) begin
          addr_d  = ptr_q;
          we_d    = 1'b1;
          wdata_d = {8{color_q}};
          if (ptr_q == LAST_PTR) begin
            ptr_d      = 9'd0;
            clr_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            ptr_d = ptr_q + 9'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, clear pointer, sticky conflict and the display return pipeline.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= 9'd0;
      color_q      <= 4'd0;
      conflict_q   <= 1'b0;
      clr_done_q   <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_sel_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      color_q      <= color_d;
      conflict_q   <= conflict_d;
      clr_done_q   <= clr_done_d;
      disp_valid_q <= bus.disp_rd;
      disp_sel_q   <= bus.disp_sel;
    end
  end

  // Reset suppresses the memory operation immediately so an interrupted
  // RMW or clear never commits another word.
  assign bus.mem_addr   = rst ? 9'd0  : addr_d;
  assign bus.mem_we     = we_d & ~rst;
  assign bus.mem_wdata  = rst ? 32'd0 : wdata_d;
  assign bus.wr_ack     = ack_d & ~rst;
  assign bus.clr_done   = clr_done_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.conflict   = conflict_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_pixel = disp_valid_q ? bus.mem_rdata[{disp_sel_q, 2'b00} +: 4] : 4'd0;
  assign dbg_state_o    = state_q;

endmodule

// File: doc/pixel_mem_arbiter.md
PIXEL_MEM_ARBITER -- requirements
Module: pixel_mem_arbiter

Interface
REQ-001 Parameter: WORDS, 384, number of frame-buffer words (48 rows x 8 words of 8 pixels).
REQ-002 clk_25  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 disp_rd  in  1  display read request; one-cycle strobe per pixel.
REQ-005 disp_addr  in  9  display word address.
REQ-006 disp_sel  in  3  display pixel index within word.
REQ-007 mem_row  in  1  high while display is on a memory-reading row; host traffic not granted.
REQ-008 disp_pixel  out  4  selected pixel from returned read data.
REQ-009 disp_valid  out  1  disp_pixel valid this cycle.
REQ-010 wr_req  in  1  host single-pixel write request; inputs held stable until wr_ack.
REQ-011 wr_addr  in  9  host word address.
REQ-012 wr_sel  in  3  host pixel index.
REQ-013 wr_pix  in  4  host pixel value.
REQ-014 wr_ack  out  1  one-cycle pulse: write committed.
REQ-015 clr_req  in  1  request to fill whole buffer with clr_color.
REQ-016 clr_color  in  4  fill colour, sampled at clear start.
REQ-017 clr_done  out  1  one-cycle pulse: clear finished.
REQ-018 busy  out  1  high while in a host-write or clear state.
REQ-019 conflict  out  1  sticky flag: a host write was aborted by a display read.
REQ-020 mem_addr  out  9  memory address.
REQ-021 mem_we  out  1  memory write enable.
REQ-022 mem_wdata  out  32  memory write data; pixel k in bits [4k+3:4k].
REQ-023 mem_rdata  in  32  memory read data, valid the cycle after address with mem_we=0.

Function
REQ-024 States: IDLE, WR_RD, WR_WB, CLR; exactly one memory operation per cycle.
REQ-025 disp_rd has absolute priority in every state: mem_addr=disp_addr, mem_we=0 that cycle.
REQ-026 disp_valid = disp_rd delayed one cycle; disp_pixel = mem_rdata nibble at registered disp_sel, 0 when disp_valid=0.
REQ-027 From IDLE, grant only when disp_rd=0 and mem_row=0; clr_req beats wr_req when both pending.
REQ-028 Grant clear: latch clr_color, clear pointer=0, go CLR.
REQ-029 Grant write: go WR_RD; WR_RD drives mem_addr=wr_addr, mem_we=0, next state WR_WB.
REQ-030 WR_WB: mem_addr=wr_addr, mem_we=1, mem_wdata=mem_rdata with nibble wr_sel replaced by wr_pix, wr_ack=1 same cycle, next IDLE.
REQ-031 disp_rd in WR_RD or WR_WB: abort RMW, no write, no wr_ack, set conflict, next IDLE; write regranted later.
REQ-032 CLR: if disp_rd=0 and mem_row=0, write {8{colour}} to pointer and increment; otherwise hold pointer, no write.
REQ-033 Clear write at pointer=WORDS-1: next state IDLE, clr_done=1 next cycle; pointer returns to 0.
REQ-034 wr_req during CLR waits; clr_req during write waits; clr_req while in CLR ignored.
REQ-035 busy=1 in WR_RD, WR_WB, CLR; mem_we=0 and mem_addr=0 in IDLE with no disp_rd.

Reset
REQ-036 rst: state IDLE, pointer 0, conflict 0, disp_valid/wr_ack/clr_done/busy/mem_we 0, mem_addr 0.
REQ-037 rst mid-RMW or mid-clear abandons operation: no wr_ack, no clr_done, no further writes.

Verification
REQ-038 wr_req addr=5 sel=3 pix=0xA, mem word 0x12345678, idle -> cycle1 read addr5, cycle2 mem_we=1 wdata=0x1234A678, wr_ack=1.
REQ-039 disp_rd addr=7 sel=0, mem[7]=0x0000000F -> next cycle disp_valid=1, disp_pixel=0xF.
REQ-040 wr_req granted, disp_rd in WR_WB cycle -> no write, no wr_ack, conflict=1, RMW retried and acked later.
REQ-041 clr_req color=0x3, no display traffic -> 384 writes of 0x33333333 addr 0..383, clr_done one cycle after last.
REQ-042 mem_row=1 during clear for 10 cycles -> no writes, pointer held; resumes at same address after mem_row falls.
REQ-043 rst asserted at pointer=100 of clear -> busy=0, mem_we=0 next cycle, no clr_done.
